// File: rtl/tohost_monitor.sv
// tohost completion monitor: snoops DUT stores to the tohost word and
// reports pass/fail, forwards host requests and returns fromhost pulses.
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   wr_valid/addr/data    snooped DUT store beat (no backpressure)
//   req_valid/ready/bits  host request channel (raw tohost value)
//   resp_valid/ready/bits host response channel
//   fromhost_valid/data   one-cycle write of the host response
//   io_success            sticky pass
//   io_failure            sticky fail
//   timeout               failure was caused by the watchdog
//   exit_code             failure code
module tohost_monitor #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [63:0]       req_bits,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [63:0]       resp_bits,
  output logic              fromhost_valid,
  output logic [63:0]       fromhost_data,
  output logic              io_success,
  output logic              io_failure,
  output logic              timeout,
  output logic [31:0]       exit_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PASS,
    S_FAIL
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TIMEOUT_CYCLES) - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0] CODE_PROTO = 32'hFFFF_FFFE;
  localparam logic [31:0] CODE_WD    = 32'hFFFF_FFFF;

  state_t            state_q, state_d;
  logic [63:0]       req_bits_q, req_bits_d;
  logic              fh_valid_q, fh_valid_d;
  logic [63:0]       fh_data_q, fh_data_d;
  logic [31:0]       code_q, code_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic hit;
  logic active;
  logic expire;

  // Zero stores are the host clearing tohost, never a command.
  assign hit = wr_valid
             && (wr_addr == TOHOST_ADDR)
             && (wr_data != 64'd0);

  assign active = (state_q == S_IDLE)
               || (state_q == S_REQ)
               || (state_q == S_WAIT);

  assign expire = WD_EN && (cnt_q == LIMIT);

  always_comb begin
    state_d    = state_q;
    req_bits_d = req_bits_q;
    fh_valid_d = 1'b0;
    fh_data_d  = fh_data_q;
    code_d     = code_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;

    if (active && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (wr_data == 64'd1) begin
            state_d = S_PASS;
          end else if (wr_data[0]) begin
            state_d = S_FAIL;
            code_d  = wr_data[32:1];
          end else begin
            state_d    = S_REQ;
            req_bits_d = wr_data;
          end
        end else if (expire) begin
          state_d = S_FAIL;
          tmo_d   = 1'b1;
          code_d  = CODE_WD;
        end
      end
      S_REQ: begin
        if (hit) begin
          state_d = S_FAIL;
          code_d  = CODE_PROTO;
        end else if (expire) begin
          state_d = S_FAIL;
          tmo_d   = 1'b1;
          code_d  = CODE_WD;
        end else if (req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A hit beats a same-cycle response: no fromhost pulse.
        if (hit) begin
          state_d = S_FAIL;
          code_d  = CODE_PROTO;
        end else if (expire) begin
          state_d = S_FAIL;
          tmo_d   = 1'b1;
          code_d  = CODE_WD;
        end else if (resp_valid) begin
          state_d    = S_IDLE;
          fh_valid_d = 1'b1;
          fh_data_d  = resp_bits;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_bits_q <= '0;
      fh_valid_q <= 1'b0;
      fh_data_q  <= '0;
      code_q     <= '0;
      tmo_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_bits_q <= req_bits_d;
      fh_valid_q <= fh_valid_d;
      fh_data_q  <= fh_data_d;
      code_q     <= code_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_valid      = (state_q == S_REQ);
  assign resp_ready     = (state_q == S_WAIT);
  assign req_bits       = req_bits_q;
  assign fromhost_valid = fh_valid_q;
  assign fromhost_data  = fh_data_q;
  assign io_success     = (state_q == S_PASS);
  assign io_failure     = (state_q == S_FAIL);
  assign timeout        = tmo_q;
  assign exit_code      = code_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: two instances (watchdog off / 50 cycles)
// share one directed stimulus and are checked against a model.
module tb_tohost_monitor;

  localparam logic [31:0] TA = 32'h8000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_bits = '0;

  logic        req_valid [2];
  logic [63:0] req_bits [2];
  logic        resp_ready [2];
  logic        fh_valid [2];
  logic [63:0] fh_data [2];
  logic        io_success [2];
  logic        io_failure [2];
  logic        timeout [2];
  logic [31:0] exit_code [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tohost_monitor #(.TIMEOUT_CYCLES(0)) u_dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid[0]), .req_ready(req_ready),
    .req_bits(req_bits[0]),
    .resp_valid(resp_valid), .resp_ready(resp_ready[0]),
    .resp_bits(resp_bits),
    .fromhost_valid(fh_valid[0]), .fromhost_data(fh_data[0]),
    .io_success(io_success[0]), .io_failure(io_failure[0]),
    .timeout(timeout[0]), .exit_code(exit_code[0])
  );

  tohost_monitor #(.TIMEOUT_CYCLES(50)) u_wd (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid[1]), .req_ready(req_ready),
    .req_bits(req_bits[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready[1]),
    .resp_bits(resp_bits),
    .fromhost_valid(fh_valid[1]), .fromhost_data(fh_data[1]),
    .io_success(io_success[1]), .io_failure(io_failure[1]),
    .timeout(timeout[1]), .exit_code(exit_code[1])
  );

  typedef struct {
    bit        pass;
    bit        fail;
    bit        tmo;
    bit [31:0] code;
    bit        rq;
    bit [63:0] rb;
    bit        wt;
    bit        fv;
    bit [63:0] fd;
    longint    cyc;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t step(mdl_t c, longint lim);
    mdl_t n;
    bit   hit;
    n    = c;
    n.fv = 1'b0;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    hit = wr_valid && (wr_addr == TA) && (wr_data != 0);
    if (!(c.pass || c.fail)) begin
      if (hit && (c.rq || c.wt)) begin
        n.fail = 1; n.code = 32'hFFFF_FFFE; n.rq = 0; n.wt = 0;
      end else if (hit) begin
        if (wr_data == 1) n.pass = 1;
        else if (wr_data[0]) begin
          n.fail = 1; n.code = wr_data[32:1];
        end else begin
          n.rq = 1; n.rb = wr_data;
        end
      end else if (lim != 0 && c.cyc == lim - 1) begin
        n.fail = 1; n.tmo = 1; n.code = 32'hFFFF_FFFF;
        n.rq = 0; n.wt = 0;
      end else if (c.rq && req_ready) begin
        n.rq = 0; n.wt = 1;
      end else if (c.wt && resp_valid) begin
        n.wt = 0; n.fv = 1; n.fd = resp_bits;
      end
      n.cyc = c.cyc + 1;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    m[0] <= step(m[0], 0);
    m[1] <= step(m[1], 50);
  end

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("m%0d io_success", k), 64'(io_success[k]),
          64'(m[k].pass));
      cmp($sformatf("m%0d io_failure", k), 64'(io_failure[k]),
          64'(m[k].fail));
      cmp($sformatf("m%0d timeout", k), 64'(timeout[k]),
          64'(m[k].tmo));
      cmp($sformatf("m%0d exit_code", k), 64'(exit_code[k]),
          64'(m[k].code));
      cmp($sformatf("m%0d req_valid", k), 64'(req_valid[k]),
          64'(m[k].rq));
      cmp($sformatf("m%0d req_bits", k), req_bits[k], m[k].rb);
      cmp($sformatf("m%0d resp_ready", k), 64'(resp_ready[k]),
          64'(m[k].wt));
      cmp($sformatf("m%0d fh_valid", k), 64'(fh_valid[k]),
          64'(m[k].fv));
      cmp($sformatf("m%0d fh_data", k), fh_data[k], m[k].fd);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rst();
    reset = 1'b1;
    wr_valid = 1'b0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic store(logic [31:0] a, logic [63:0] d);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc(1);
    wr_valid = 1'b0;
    wr_data = '0;
  endtask

  initial begin
    rst();
    cmp("reset success", 64'(io_success[0]), 0);
    cmp("reset failure", 64'(io_failure[0]), 0);

    // pass, sticky
    store(TA, 64'h1);
    cmp("t1 success", 64'(io_success[0]), 1);
    cmp("t1 failure", 64'(io_failure[0]), 0);
    cyc(100);
    cmp("t1 sticky", 64'(io_success[0]), 1);

    // fail with code, later pass ignored
    rst();
    store(TA, 64'h7);
    cmp("t2 failure", 64'(io_failure[0]), 1);
    cmp("t2 code", 64'(exit_code[0]), 3);
    store(TA, 64'h1);
    cmp("t2 no success", 64'(io_success[0]), 0);

    // wrong address, zero store
    rst();
    store(TA + 32'd8, 64'h1);
    store(TA, 64'h0);
    cyc(3);
    cmp("t3 success", 64'(io_success[0]), 0);
    cmp("t3 failure", 64'(io_failure[0]), 0);
    cmp("t3 req_valid", 64'(req_valid[0]), 0);

    // host request round trip
    rst();
    store(TA, 64'h1000);
    for (int i = 0; i < 5; i++) begin
      cmp("t4 req_valid", 64'(req_valid[0]), 1);
      cmp("t4 req_bits", req_bits[0], 64'h1000);
      cyc(1);
    end
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
    cmp("t4 req dropped", 64'(req_valid[0]), 0);
    cmp("t4 resp_ready", 64'(resp_ready[0]), 1);
    cyc(1);
    resp_valid = 1'b1;
    resp_bits = 64'h1;
    cyc(1);
    resp_valid = 1'b0;
    cmp("t4 fh pulse", 64'(fh_valid[0]), 1);
    cmp("t4 fh data", fh_data[0], 64'h1);
    cyc(1);
    cmp("t4 fh single", 64'(fh_valid[0]), 0);
    cmp("t4 idle", 64'(resp_ready[0]), 0);
    store(TA, 64'h1);
    cmp("t4 success", 64'(io_success[0]), 1);

    // hit during REQ
    rst();
    store(TA, 64'h1000);
    cyc(1);
    store(TA, 64'h2000);
    cmp("t5 failure", 64'(io_failure[0]), 1);
    cmp("t5 code", 64'(exit_code[0]), 64'hFFFF_FFFE);
    cmp("t5 req_valid", 64'(req_valid[0]), 0);

    // hit and response in same WAIT cycle
    rst();
    store(TA, 64'h10);
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_bits = 64'h55;
    store(TA, 64'h20);
    resp_valid = 1'b0;
    cmp("t6 failure", 64'(io_failure[0]), 1);
    cmp("t6 code", 64'(exit_code[0]), 64'hFFFF_FFFE);
    cmp("t6 no fh", 64'(fh_valid[0]), 0);

    // watchdog expiry at cycle 50
    rst();
    cyc(49);
    cmp("t7 before", 64'(io_failure[1]), 0);
    cyc(1);
    cmp("t7 failure", 64'(io_failure[1]), 1);
    cmp("t7 timeout", 64'(timeout[1]), 1);
    cmp("t7 code", 64'(exit_code[1]), 64'hFFFF_FFFF);
    cmp("t7 wd off", 64'(io_failure[0]), 0);

    // pass in the expiry cycle wins
    rst();
    cyc(49);
    store(TA, 64'h1);
    cmp("t8 success", 64'(io_success[1]), 1);
    cmp("t8 timeout", 64'(timeout[1]), 0);

    // reset mid-REQ
    rst();
    store(TA, 64'h1000);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    cmp("t9 req_valid", 64'(req_valid[0]), 0);
    cmp("t9 req_bits", req_bits[0], 0);
    cmp("t9 failure", 64'(io_failure[0]), 0);
    reset = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
